// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the interconnect slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ahb_ic_default_slave.sv
// Default slave: two-cycle ERROR for unmapped transfers.
// HREADY_TIMEOUT_EN adds a watchdog trigger into the same sequence.
module ahb_ic_default_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hready,
  input  logic unmapped,
  input  logic trans_active,
`ifdef HREADY_TIMEOUT_EN
  input  logic timeout_trig,
`endif
  output logic ds_hready,
  output logic ds_hresp,
  output logic ds_busy
);

  ds_state_t state;

  assign ds_busy = (state != DS_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DS_IDLE;
      ds_hready <= 1'b1;
      ds_hresp  <= HRESP_OKAY;
    end else begin
      unique case (state)
        DS_IDLE: begin
          if (hready && unmapped && trans_active) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
          end
`ifdef HREADY_TIMEOUT_EN
          else if (timeout_trig) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
          end
`endif
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          ds_hready <= 1'b1;
          ds_hresp  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (unmapped && trans_active) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
          end else begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
          end
        end
        default: begin
          state     <= DS_IDLE;
          ds_hready <= 1'b1;
          ds_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_interconnect_n.sv
// Single-master AHB-Lite interconnect: decode, response mux, default slave.
// Optional HREADY_TIMEOUT_EN aborts stalled slaves after TIMEOUT_CYCLES.
module ahb_interconnect_n
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS =
    {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS =
    {4{32'hF000_0000}},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         in_HCLK,
  input  logic                         in_HRESET,
  input  logic [ADDR_W-1:0]            in_HADDR,
  input  logic [1:0]                   in_HTRANS,
  input  logic                         in_HWRITE,
  output logic [NUM_SLAVES-1:0]        out_HSEL,
  input  logic [NUM_SLAVES-1:0]        in_HREADY_S,
  input  logic [NUM_SLAVES-1:0]        in_HRESP_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] in_HRDATA_S,
  output logic                         out_HREADY,
  output logic                         out_HRESP,
  output logic [DATA_W-1:0]            out_HRDATA,
  output logic                         out_timeout
);

  localparam int SEL_W = clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(NUM_SLAVES);

  logic [SEL_W-1:0]  win;
  logic [SEL_W-1:0]  dsel;
  logic              found;
  logic              unmapped;
  logic              ds_hready;
  logic              ds_hresp;
  logic              ds_busy;
  logic              sel_hready;
  logic              sel_hresp;
  logic [DATA_W-1:0] sel_hrdata;
  logic              use_ds;
  logic              unused_ok;

  assign unused_ok = ^{in_HWRITE, in_HTRANS[0]};

  // Lowest index wins when regions overlap.
  always_comb begin
    out_HSEL = '0;
    win      = DEF_SEL;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found &&
          ((in_HADDR & ADDR_MASKS[i*ADDR_W +: ADDR_W]) ==
           (BASE_ADDRS[i*ADDR_W +: ADDR_W] &
            ADDR_MASKS[i*ADDR_W +: ADDR_W]))) begin
        found       = 1'b1;
        win         = SEL_W'(i);
        out_HSEL[i] = 1'b1;
      end
    end
  end

  assign unmapped = !found;

  always_ff @(posedge in_HCLK or negedge in_HRESET) begin
    if (!in_HRESET) dsel <= DEF_SEL;
    else if (out_HREADY) dsel <= win;
  end

  always_comb begin
    sel_hready = 1'b1;
    sel_hresp  = HRESP_OKAY;
    sel_hrdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == SEL_W'(i)) begin
        sel_hready = in_HREADY_S[i];
        sel_hresp  = in_HRESP_S[i];
        sel_hrdata = in_HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

  // An active error sequence owns the bus even over a stalled slave.
  assign use_ds     = ds_busy || (dsel == DEF_SEL);
  assign out_HREADY = use_ds ? ds_hready : sel_hready;
  assign out_HRESP  = use_ds ? ds_hresp : sel_hresp;
  assign out_HRDATA = use_ds ? '0 : sel_hrdata;

`ifdef HREADY_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             stall;
  logic             to_trig;

  assign stall   = !use_ds && !sel_hready;
  assign to_trig = stall &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge in_HCLK or negedge in_HRESET) begin
    if (!in_HRESET) begin
      to_cnt      <= '0;
      out_timeout <= 1'b0;
    end else begin
      out_timeout <= to_trig;
      if (stall && !to_trig) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
    end
  end
`else
  assign out_timeout = 1'b0;
`endif

  ahb_ic_default_slave u_def (
    .clk          (in_HCLK),
    .rst_n        (in_HRESET),
    .hready       (out_HREADY),
    .unmapped     (unmapped),
    .trans_active (in_HTRANS[1]),
`ifdef HREADY_TIMEOUT_EN
    .timeout_trig (to_trig),
`endif
    .ds_hready    (ds_hready),
    .ds_hresp     (ds_hresp),
    .ds_busy      (ds_busy)
  );

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Vector table plus scoreboard checks for ahb_interconnect_n.
module tb_ahb_interconnect_n;

  localparam logic [31:0] U  = 32'h9000_0000;
  localparam logic [1:0]  TI = 2'b00;
  localparam logic [1:0]  TN = 2'b10;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [3:0]  sel;
    logic        hr;
    logic        rp;
    logic [31:0] rd;
    logic        to;
  } vec_t;

  typedef struct {
    logic [3:0]  sel;
    logic        hr;
    logic        rp;
    logic [31:0] rd;
    logic        to;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  haddr = U;
  logic [1:0]   htrans = TI;
  logic         hwrite = 1'b0;
  logic [3:0]   hsel;
  logic [3:0]   hready_s = 4'hF;
  logic [3:0]   hresp_s = 4'h0;
  logic [127:0] hrdata_s = {32'hA300_0003, 32'hA200_0002,
                            32'hCAFE_0001, 32'hA000_0000};
  logic         hready;
  logic         hresp;
  logic [31:0]  hrdata;
  logic         tout;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  ahb_interconnect_n #(.TIMEOUT_CYCLES(8)) dut (
    .in_HCLK     (clk),
    .in_HRESET   (rst_n),
    .in_HADDR    (haddr),
    .in_HTRANS   (htrans),
    .in_HWRITE   (hwrite),
    .out_HSEL    (hsel),
    .in_HREADY_S (hready_s),
    .in_HRESP_S  (hresp_s),
    .in_HRDATA_S (hrdata_s),
    .out_HREADY  (hready),
    .out_HRESP   (hresp),
    .out_HRDATA  (hrdata),
    .out_timeout (tout)
  );

  function automatic vec_t mk(
    input logic [31:0] a, input logic [1:0] t,
    input logic [3:0] rdy, input logic [3:0] rsp,
    input logic [3:0] sel, input logic hr, input logic rp,
    input logic [31:0] rd, input logic to);
    vec_t v;
    v.a = a; v.t = t; v.rdy = rdy; v.rsp = rsp;
    v.sel = sel; v.hr = hr; v.rp = rp; v.rd = rd; v.to = to;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.sel = v.sel; e.hr = v.hr; e.rp = v.rp; e.rd = v.rd; e.to = v.to;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, ".hsel"}, 32'(hsel), 32'(e.sel));
      chk({nm, ".hready"}, 32'(hready), 32'(e.hr));
      chk({nm, ".hresp"}, 32'(hresp), 32'(e.rp));
      chk({nm, ".hrdata"}, hrdata, e.rd);
      chk({nm, ".timeout"}, 32'(tout), 32'(e.to));
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    haddr = v.a; htrans = v.t; hready_s = v.rdy; hresp_s = v.rsp;
    push_exp(v);
    @(negedge clk);
    check_out(nm);
  endtask

  task automatic park_and_release();
    haddr = U; htrans = TI; hready_s = 4'hF; hresp_s = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0);
    tbl[1]  = mk(32'h2000_0010, TI, 4'hF, 4'h0, 4'b0100, 1, 0, 32'h0, 0);
    tbl[2]  = mk(32'h1000_0004, TN, 4'hF, 4'h0, 4'b0010, 1, 0,
                 32'hA200_0002, 0);
    tbl[3]  = mk(U, TI, 4'b1101, 4'h0, 4'b0000, 0, 0, 32'hCAFE_0001, 0);
    tbl[4]  = mk(U, TI, 4'b1101, 4'h0, 4'b0000, 0, 0, 32'hCAFE_0001, 0);
    tbl[5]  = mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'hCAFE_0001, 0);
    tbl[6]  = mk(U, TN, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0);
    tbl[7]  = mk(U, TI, 4'hF, 4'h0, 4'b0000, 0, 1, 32'h0, 0);
    tbl[8]  = mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 1, 32'h0, 0);
    tbl[9]  = mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0);
    tbl[10] = mk(32'h0000_0100, TN, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0);
    tbl[11] = mk(U, TN, 4'hF, 4'h0, 4'b0000, 1, 0, 32'hA000_0000, 0);
    tbl[12] = mk(32'h4000_0000, TN, 4'hF, 4'h0, 4'b1000, 0, 1, 32'h0, 0);
    tbl[13] = mk(32'h4000_0000, TN, 4'hF, 4'h0, 4'b1000, 1, 1, 32'h0, 0);
    tbl[14] = mk(U, TI, 4'hF, 4'b1000, 4'b0000, 1, 1, 32'hA300_0003, 0);
    tbl[15] = mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0);

    #11;
    push_exp(mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0));
    check_out("in_reset");
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    apply(mk(U, TN, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0), "a_addr");
    apply(mk(U, TI, 4'hF, 4'h0, 4'b0000, 0, 1, 32'h0, 0), "a_err1");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0));
    check_out("a_rst");
    haddr = 32'h0000_0020;
    #1;
    push_exp(mk(U, TI, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0));
    check_out("a_rst_hsel");
    park_and_release();
    apply(mk(32'h0000_0020, TN, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0),
          "a_next_addr");
    apply(mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'hA000_0000, 0),
          "a_next_data");

    apply(mk(32'h1000_0000, TN, 4'hF, 4'h0, 4'b0010, 1, 0, 32'h0, 0),
          "b_addr");
    apply(mk(U, TI, 4'b1101, 4'h0, 4'b0000, 0, 0, 32'hCAFE_0001, 0),
          "b_wait");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0));
    check_out("b_rst");
    park_and_release();
    apply(mk(32'h0000_0030, TN, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0),
          "b_next_addr");
    apply(mk(U, TI, 4'hF, 4'h0, 4'b0000, 1, 0, 32'hA000_0000, 0),
          "b_next_data");

`ifdef HREADY_TIMEOUT_EN
    apply(mk(32'h2000_0000, TN, 4'hF, 4'h0, 4'b0100, 1, 0, 32'h0, 0),
          "t_addr");
    for (int i = 0; i < 8; i++)
      apply(mk(U, TI, 4'b1011, 4'h0, 4'b0000, 0, 0, 32'hA200_0002, 0),
            $sformatf("t_wait%0d", i));
    apply(mk(32'h0000_0040, TN, 4'b1011, 4'h0, 4'b0001, 0, 1, 32'h0, 1),
          "t_err1");
    apply(mk(32'h0000_0040, TN, 4'b1011, 4'h0, 4'b0001, 1, 1, 32'h0, 0),
          "t_err2");
    apply(mk(U, TI, 4'b1011, 4'h0, 4'b0000, 1, 0, 32'hA000_0000, 0),
          "t_next");
`endif

    if (sbq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_drain: %0d left expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
